// File: rtl/bullet_pool.sv
// bullet_pool: multi-slot projectile manager for the VGA game layer.
// Launches, moves, draws and collision-checks up to NUM_SLOTS bullets.
module bullet_pool #(
    parameter int NUM_SLOTS = 4,
    parameter int XSIZE     = 3,
    parameter int YSIZE     = 5,
    parameter int DIR_UP    = 1,
    parameter int STEP      = 1,
    parameter int COOLDOWN  = 8,
    parameter int Y_MIN     = 0,
    parameter int Y_MAX     = 479
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pixpulse,
    input  logic [9:0]           hcount,
    input  logic [9:0]           vcount,
    input  logic                 empty,
    input  logic                 move,
    input  logic                 fire,
    input  logic [9:0]           fire_x,
    input  logic [9:0]           fire_y,
    output logic                 draw_bullet,
    output logic [NUM_SLOTS-1:0] active,
    output logic                 fire_ack,
    output logic [NUM_SLOTS-1:0] hit_mask,
    output logic [9:0]           hit_x,
    output logic [9:0]           hit_y
);

    localparam logic [10:0] HX  = 11'((XSIZE - 1) / 2);
    localparam logic [10:0] HY  = 11'((YSIZE - 1) / 2);
    localparam logic [10:0] STP = 11'(STEP);
    localparam logic [10:0] YLO = 11'(Y_MIN);
    localparam logic [10:0] YHI = 11'(Y_MAX);
    localparam logic [9:0]  STP10 = 10'(STEP);
    localparam int          CW = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);
    localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN);

    logic [NUM_SLOTS-1:0] act_q, act_d;
    logic [NUM_SLOTS-1:0] blk_q, blk_d;
    logic [9:0]           x_q [NUM_SLOTS];
    logic [9:0]           x_d [NUM_SLOTS];
    logic [9:0]           y_q [NUM_SLOTS];
    logic [9:0]           y_d [NUM_SLOTS];
    logic [CW-1:0]        cd_q, cd_d;
    logic                 ack_q, ack_d;
    logic [NUM_SLOTS-1:0] hm_q, hm_d;
    logic [9:0]           hx_q, hx_d;
    logic [9:0]           hy_q, hy_d;

    logic [NUM_SLOTS-1:0] scan_hit;
    logic [NUM_SLOTS-1:0] expire;
    logic [NUM_SLOTS-1:0] free_oh;
    logic [NUM_SLOTS-1:0] hit_vec;
    logic [NUM_SLOTS-1:0] hit_oh;
    logic                 accept;
    logic                 draw;
    logic [9:0]           hit_xs;
    logic [9:0]           hit_ys;

    // Per-slot geometry: pixel cover, ahead-row obstacle scan and travel limit
    always_comb begin
        logic [10:0] h11, v11, x11, y11, ahead;
        logic        in_h, in_v, ahead_ok;
        draw     = 1'b0;
        scan_hit = '0;
        expire   = '0;
        h11 = {1'b0, hcount};
        v11 = {1'b0, vcount};
        for (int i = 0; i < NUM_SLOTS; i++) begin
            x11  = {1'b0, x_q[i]};
            y11  = {1'b0, y_q[i]};
            in_h = (h11 + HX >= x11) && (h11 <= x11 + HX);
            in_v = (v11 + HY >= y11) && (v11 <= y11 + HY);
            if (DIR_UP != 0) begin
                ahead_ok  = (y11 >= HY + 11'd1);
                ahead     = y11 - HY - 11'd1;
                expire[i] = (y11 < YLO + STP);
            end else begin
                ahead_ok  = 1'b1;
                ahead     = y11 + HY + 11'd1;
                expire[i] = (y11 + STP > YHI);
            end
            draw = draw | (act_q[i] & in_h & in_v);
            scan_hit[i] = act_q[i] & ~empty & ahead_ok
                        & (v11 == ahead) & in_h;
        end
    end

    // Lowest free slot, lowest hit slot and its pre-move centre
    always_comb begin
        free_oh = ~act_q & (act_q + NUM_SLOTS'(1));
        hit_vec = act_q & blk_q;
        hit_oh  = hit_vec & (~hit_vec + NUM_SLOTS'(1));
        accept  = fire & (cd_q == '0) & (|(~act_q));
        hit_xs  = '0;
        hit_ys  = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (hit_oh[i]) begin
                hit_xs = hit_xs | x_q[i];
                hit_ys = hit_ys | y_q[i];
            end
        end
    end

    // Next state: move/terminate, scan, launch and cooldown on pixel enables
    always_comb begin
        act_d = act_q;
        blk_d = blk_q;
        cd_d  = cd_q;
        ack_d = 1'b0;
        hm_d  = '0;
        hx_d  = hx_q;
        hy_d  = hy_q;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            x_d[i] = x_q[i];
            y_d[i] = y_q[i];
        end
        if (pixpulse) begin
            if (move) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (act_q[i]) begin
                        if (blk_q[i] || expire[i]) begin
                            act_d[i] = 1'b0;
                        end else if (DIR_UP != 0) begin
                            y_d[i] = y_q[i] - STP10;
                        end else begin
                            y_d[i] = y_q[i] + STP10;
                        end
                    end
                end
                blk_d = '0;
                hm_d  = hit_vec;
                if (|hit_vec) begin
                    hx_d = hit_xs;
                    hy_d = hit_ys;
                end
                if (cd_q != '0) cd_d = cd_q - CW'(1);
            end else begin
                blk_d = blk_q | scan_hit;
            end
            if (accept) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (free_oh[i]) begin
                        act_d[i] = 1'b1;
                        blk_d[i] = 1'b0;
                        x_d[i]   = fire_x;
                        y_d[i]   = fire_y;
                    end
                end
                cd_d  = CD_LOAD;
                ack_d = 1'b1;
            end
        end
    end

    // State registers; reset discards all bullets and pending reports
    always_ff @(posedge clk) begin
        if (!rst) begin
            act_q <= '0;
            blk_q <= '0;
            cd_q  <= '0;
            ack_q <= 1'b0;
            hm_q  <= '0;
            hx_q  <= '0;
            hy_q  <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            act_q <= act_d;
            blk_q <= blk_d;
            cd_q  <= cd_d;
            ack_q <= ack_d;
            hm_q  <= hm_d;
            hx_q  <= hx_d;
            hy_q  <= hy_d;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                x_q[i] <= x_d[i];
                y_q[i] <= y_d[i];
            end
        end
    end

    assign draw_bullet = draw;
    assign active      = act_q;
    assign fire_ack    = ack_q;
    assign hit_mask    = hm_q;
    assign hit_x       = hx_q;
    assign hit_y       = hy_q;

endmodule

// File: tb/tb_bullet_pool.sv
// tb_bullet_pool: directed scenarios plus random traffic against a
// slot-list model of the bullet pool, checked on every clock.
module tb_bullet_pool;

    localparam int N    = 4;
    localparam int HX   = 1;
    localparam int HY   = 2;
    localparam int STEP = 1;
    localparam int CD   = 2;
    localparam int YMIN = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pixpulse = 1'b0;
    logic [9:0] hcount = '0;
    logic [9:0] vcount = '0;
    logic       empty = 1'b1;
    logic       move = 1'b0;
    logic       fire = 1'b0;
    logic [9:0] fire_x = '0;
    logic [9:0] fire_y = '0;
    logic         draw_bullet;
    logic [N-1:0] active;
    logic         fire_ack;
    logic [N-1:0] hit_mask;
    logic [9:0]   hit_x;
    logic [9:0]   hit_y;

    always #5 clk = ~clk;

    bullet_pool #(
        .NUM_SLOTS(N), .XSIZE(3), .YSIZE(5), .DIR_UP(1), .STEP(STEP),
        .COOLDOWN(CD), .Y_MIN(YMIN), .Y_MAX(479)
    ) dut (
        .clk(clk), .rst(rst), .pixpulse(pixpulse),
        .hcount(hcount), .vcount(vcount), .empty(empty),
        .move(move), .fire(fire), .fire_x(fire_x), .fire_y(fire_y),
        .draw_bullet(draw_bullet), .active(active), .fire_ack(fire_ack),
        .hit_mask(hit_mask), .hit_x(hit_x), .hit_y(hit_y)
    );

    int m_act [N];
    int m_x   [N];
    int m_y   [N];
    int m_blk [N];
    int m_cd;
    int e_ack, e_hm, e_hx, e_hy;
    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 0;
    int got_ack, got_hm;

    function automatic void m_reset();
        for (int i = 0; i < N; i++) begin
            m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_blk[i] = 0;
        end
        m_cd = 0; e_ack = 0; e_hm = 0; e_hx = 0; e_hy = 0;
    endfunction

    // One clock of the pool as the rules describe it
    function automatic void m_edge();
        int pre [N];
        int cd0, slot, first, hc, vc;
        e_ack = 0;
        e_hm = 0;
        if (!pixpulse) return;
        hc = int'(hcount);
        vc = int'(vcount);
        cd0 = m_cd;
        slot = -1;
        first = -1;
        for (int i = 0; i < N; i++) pre[i] = m_act[i];
        for (int i = N - 1; i >= 0; i--) if (pre[i] == 0) slot = i;
        if (move) begin
            for (int i = 0; i < N; i++) begin
                if (pre[i] != 0) begin
                    if (m_blk[i] != 0) begin
                        e_hm |= (1 << i);
                        if (first < 0) first = i;
                        m_act[i] = 0;
                    end else if (m_y[i] < YMIN + STEP) begin
                        m_act[i] = 0;
                    end else begin
                        m_y[i] -= STEP;
                    end
                end
                m_blk[i] = 0;
            end
            if (first >= 0) begin
                e_hx = m_x[first];
                e_hy = m_y[first];
            end
            if (m_cd > 0) m_cd--;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (pre[i] != 0 && !empty && m_y[i] - HY - 1 >= 0
                    && vc == m_y[i] - HY - 1
                    && hc >= m_x[i] - HX && hc <= m_x[i] + HX)
                    m_blk[i] = 1;
            end
        end
        if (fire && cd0 == 0 && slot >= 0) begin
            m_act[slot] = 1;
            m_blk[slot] = 0;
            m_x[slot] = int'(fire_x);
            m_y[slot] = int'(fire_y);
            m_cd = CD;
            e_ack = 1;
        end
    endfunction

    function automatic int m_draw(int h, int v);
        int d = 0;
        for (int i = 0; i < N; i++) begin
            if (m_act[i] != 0 && h - m_x[i] <= HX && m_x[i] - h <= HX
                && v - m_y[i] <= HY && m_y[i] - v <= HY)
                d = 1;
        end
        return d;
    endfunction

    function automatic int m_active();
        int a = 0;
        for (int i = 0; i < N; i++) if (m_act[i] != 0) a |= (1 << i);
        return a;
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    always @(posedge clk) begin
        if (!rst) m_reset();
        else m_edge();
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("active", int'(active), m_active());
            chk("fire_ack", int'(fire_ack), e_ack);
            chk("hit_mask", int'(hit_mask), e_hm);
            chk("hit_x", int'(hit_x), e_hx);
            chk("hit_y", int'(hit_y), e_hy);
            chk("draw", int'(draw_bullet),
                m_draw(int'(hcount), int'(vcount)));
        end
    end

    task automatic do_reset();
        rst = 1'b0;
        pixpulse = 1'b1;
        move = 1'b1;
        fire = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        pixpulse = 1'b0;
        move = 1'b0;
        fire = 1'b0;
        chk_en = 1;
    endtask

    task automatic tick(input bit mv, input bit fr, input bit emp,
                        input int hc, input int vc,
                        input int fx, input int fy);
        pixpulse = 1'b1;
        move = mv;
        fire = fr;
        empty = emp;
        hcount = 10'(hc);
        vcount = 10'(vc);
        fire_x = 10'(fx);
        fire_y = 10'(fy);
        @(posedge clk); #1;
        got_ack = int'(fire_ack);
        got_hm = int'(hit_mask);
        pixpulse = 1'b0;
        move = 1'b0;
        fire = 1'b0;
        empty = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic probe(input int h, input int v, input int exp,
                         input string nm);
        @(posedge clk); #1;
        hcount = 10'(h);
        vcount = 10'(v);
        #1;
        chk(nm, int'(draw_bullet), exp);
    endtask

    initial begin
        int ackbits;
        // reset then idle frames
        do_reset();
        chk("rst_active", int'(active), 0);
        chk("rst_draw", int'(draw_bullet), 0);
        tick(1, 0, 1, 5, 5, 0, 0);
        tick(1, 0, 1, 7, 9, 0, 0);
        chk("idle_ack", got_ack, 0);
        chk("idle_hm", got_hm, 0);
        chk("idle_active", int'(active), 0);

        // launch and travel 10 rows up
        do_reset();
        tick(0, 1, 1, 0, 0, 100, 200);
        chk("launch_ack", got_ack, 1);
        chk("launch_active", int'(active), 1);
        repeat (10) tick(1, 0, 1, 0, 0, 0, 0);
        probe(100, 190, 1, "draw_centre");
        probe(99, 188, 1, "draw_topleft");
        probe(101, 192, 1, "draw_botright");
        probe(98, 190, 0, "draw_left_out");
        probe(102, 190, 0, "draw_right_out");
        probe(100, 187, 0, "draw_top_out");
        probe(100, 193, 0, "draw_bot_out");

        // collision: misses first, then a hit in the ahead row
        do_reset();
        tick(0, 1, 1, 0, 0, 100, 200);
        tick(0, 0, 0, 102, 197, 0, 0);
        tick(0, 0, 0, 100, 198, 0, 0);
        tick(1, 0, 1, 0, 0, 0, 0);
        chk("nohit_hm", got_hm, 0);
        chk("nohit_active", int'(active), 1);
        tick(0, 0, 0, 99, 196, 0, 0);
        tick(1, 0, 1, 0, 0, 0, 0);
        chk("hit_hm", got_hm, 1);
        chk("hit_x_lit", int'(hit_x), 100);
        chk("hit_y_lit", int'(hit_y), 199);
        chk("hit_active", int'(active), 0);

        // ahead row above the screen top never matches; then expiry
        do_reset();
        tick(0, 1, 1, 0, 0, 50, 2);
        tick(0, 0, 0, 50, 1023, 0, 0);
        tick(1, 0, 1, 0, 0, 0, 0);
        chk("top_nohit_hm", got_hm, 0);
        chk("top_nohit_active", int'(active), 1);
        tick(1, 0, 1, 0, 0, 0, 0);
        tick(1, 0, 1, 0, 0, 0, 0);
        chk("expire_hm", got_hm, 0);
        chk("expire_active", int'(active), 0);

        // fire every frame: cooldown spacing, full pool, freed-slot rule
        do_reset();
        ackbits = 0;
        for (int f = 0; f < 14; f++) begin
            tick(1, 1, 1, 0, 0, (f == 0) ? 10 : 100 + 40 * f,
                 (f == 0) ? 11 : 300);
            if (got_ack != 0) ackbits |= (1 << f);
            if (f == 12) chk("full_active", int'(active), 14);
        end
        chk("ack_frames", ackbits, 8777);
        chk("refill_active", int'(active), 15);
        probe(620, 300, 1, "refill_draw");

        // random traffic
        do_reset();
        for (int t = 0; t < 1500; t++) begin
            int hc, vc, j, fy;
            if ($urandom_range(0, 299) == 0) do_reset();
            hc = int'($urandom_range(0, 1023));
            vc = int'($urandom_range(0, 1023));
            if (m_active() != 0 && $urandom_range(0, 1) == 1) begin
                j = int'($urandom_range(0, N - 1));
                while (m_act[j] == 0) j = (j + 1) % N;
                hc = m_x[j] + int'($urandom_range(0, 4)) - 2;
                vc = m_y[j] - HY - 1 + int'($urandom_range(0, 2)) - 1;
                if (hc < 0) hc = 0;
                if (vc < 0) vc = 1023;
            end
            fy = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7))
                                              : int'($urandom_range(0, 479));
            tick($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) != 0, hc, vc,
                 int'($urandom_range(0, 639)), fy);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
